// File: rtl/ras_ckpt_stack_if.sv
// Call/return event bus between predecode, next-PC selection and the
// return-address stack. The master side raises events; the slave side is
// the stack itself and answers with the current top-of-stack prediction.
interface ras_ckpt_stack_if #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush;
    logic            push;
    logic            pop;
    logic [VLEN-1:0] push_data;
    logic            ckpt;
    logic            restore;
    logic [VLEN-1:0] top_data;
    logic            top_valid;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    modport master (
        output flush, push, pop, push_data, ckpt, restore,
        input  top_data, top_valid, count, overflow, underflow
    );

    modport slave (
        input  flush, push, pop, push_data, ckpt, restore,
        output top_data, top_valid, count, overflow, underflow
    );
endinterface

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with a single-entry checkpoint for mispredict repair.
// Circular storage: a push beyond DEPTH silently overwrites the oldest entry,
// and restore only repairs the entry the shadow pointer refers to.
module ras_ckpt_stack #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ras_ckpt_stack_if.slave   ras
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Stack storage and bookkeeping
    logic [DEPTH-1:0] valid_r;
    logic [VLEN-1:0]  addr_r [DEPTH];
    logic [PW-1:0]    tp_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;

    // Shadow (checkpoint) copy of the top entry and pointers
    logic [PW-1:0]    sh_tp_r;
    logic [CW-1:0]    sh_count_r;
    logic             sh_valid_r;
    logic [VLEN-1:0]  sh_addr_r;

    // Next-state values
    logic [DEPTH-1:0] valid_s;
    logic [VLEN-1:0]  addr_s [DEPTH];
    logic [PW-1:0]    tp_s;
    logic [CW-1:0]    count_s;
    logic             overflow_s;
    logic             underflow_s;
    logic             ckpt_en_s;

    // Pointer wrap is explicit so that non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == {PW{1'b0}}) begin
            r = PW'(DEPTH - 1);
        end else begin
            r = p - PW'(1);
        end
        return r;
    endfunction

    // Next-state logic: flush beats restore, restore beats push/pop.
    always_comb begin
        valid_s     = valid_r;
        addr_s      = addr_r;
        tp_s        = tp_r;
        count_s     = count_r;
        overflow_s  = 1'b0;
        underflow_s = 1'b0;
        ckpt_en_s   = 1'b0;

        if (ras.flush) begin
            valid_s = {DEPTH{1'b0}};
            tp_s    = {PW{1'b0}};
            count_s = {CW{1'b0}};
        end else if (ras.restore) begin
            tp_s             = sh_tp_r;
            count_s          = sh_count_r;
            valid_s[sh_tp_r] = sh_valid_r;
            addr_s[sh_tp_r]  = sh_addr_r;
        end else begin
            ckpt_en_s = ras.ckpt;
            case ({ras.push, ras.pop})
                2'b10: begin
                    tp_s         = ptr_inc(tp_r);
                    valid_s[tp_s] = 1'b1;
                    addr_s[tp_s]  = ras.push_data;
                    if (count_r == CW'(DEPTH)) begin
                        overflow_s = 1'b1;
                    end else begin
                        count_s = count_r + CW'(1);
                    end
                end
                2'b01: begin
                    if (count_r != {CW{1'b0}}) begin
                        valid_s[tp_r] = 1'b0;
                        tp_s          = ptr_dec(tp_r);
                        count_s       = count_r - CW'(1);
                    end else begin
                        underflow_s = 1'b1;
                    end
                end
                2'b11: begin
                    valid_s[tp_r] = 1'b1;
                    addr_s[tp_r]  = ras.push_data;
                    if (count_r == {CW{1'b0}}) begin
                        count_s = CW'(1);
                    end else begin
                        count_s = count_r;
                    end
                end
                default: begin
                    tp_s = tp_r;
                end
            endcase
        end
    end

    // Main stack state and event pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_r     <= {DEPTH{1'b0}};
            tp_r        <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= {VLEN{1'b0}};
            end
        end else begin
            valid_r     <= valid_s;
            addr_r      <= addr_s;
            tp_r        <= tp_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    // Checkpoint capture of the pre-update top entry and pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_tp_r    <= {PW{1'b0}};
            sh_count_r <= {CW{1'b0}};
            sh_valid_r <= 1'b0;
            sh_addr_r  <= {VLEN{1'b0}};
        end else if (ckpt_en_s) begin
            sh_tp_r    <= tp_r;
            sh_count_r <= count_r;
            sh_valid_r <= valid_r[tp_r];
            sh_addr_r  <= addr_r[tp_r];
        end else begin
            sh_tp_r    <= sh_tp_r;
            sh_count_r <= sh_count_r;
            sh_valid_r <= sh_valid_r;
            sh_addr_r  <= sh_addr_r;
        end
    end

    assign ras.top_data  = addr_r[tp_r];
    assign ras.top_valid = valid_r[tp_r];
    assign ras.count     = count_r;
    assign ras.overflow  = overflow_r;
    assign ras.underflow = underflow_r;
endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Self-checking bench for ras_ckpt_stack (DEPTH=2, VLEN=32). Each step
// drives one cycle of events, queues the hand-derived expected state, and
// compares it against the outputs one clock later.
module tb_ras_ckpt_stack;
    localparam int DEPTH = 2;
    localparam int VLEN  = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic [1:0]  count;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    ras_ckpt_stack_if #(.DEPTH(DEPTH), .VLEN(VLEN)) ras ();

    ras_ckpt_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ras    (ras.slave)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive events, queue expectation, check after the edge.
    task automatic step(input string tag, input logic rst, input logic fl, input logic pu,
                        input logic po, input logic [31:0] d, input logic ck, input logic rs,
                        input logic [31:0] e_data, input logic e_valid, input logic [1:0] e_cnt,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        rst_n         = rst;
        ras.flush     = fl;
        ras.push      = pu;
        ras.pop       = po;
        ras.push_data = d;
        ras.ckpt      = ck;
        ras.restore   = rs;
        e.data  = e_data;
        e.valid = e_valid;
        e.count = e_cnt;
        e.ovf   = e_ovf;
        e.unf   = e_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_valid"}, {31'd0, ras.top_valid}, {31'd0, e.valid});
            check_val({tag, "_count"}, {30'd0, ras.count}, {30'd0, e.count});
            check_val({tag, "_ovf"}, {31'd0, ras.overflow}, {31'd0, e.ovf});
            check_val({tag, "_unf"}, {31'd0, ras.underflow}, {31'd0, e.unf});
            if (e.valid) begin
                check_val({tag, "_data"}, ras.top_data, e.data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ras.flush = 1'b0; ras.push = 1'b0; ras.pop = 1'b0;
        ras.push_data = 32'd0; ras.ckpt = 1'b0; ras.restore = 1'b0;

        //   tag          rst  fl  pu  po  data        ck  rs  e_data      ev  cnt  ovf unf
        step("reset",     1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("push100",   1'b1,1'b0,1'b1,1'b0,32'h100, 1'b0,1'b0,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("push200",   1'b1,1'b0,1'b1,1'b0,32'h200, 1'b0,1'b0,32'h200,  1'b1,2'd2,1'b0,1'b0);
        step("pop1",      1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1'b0,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("repush200", 1'b1,1'b0,1'b1,1'b0,32'h200, 1'b0,1'b0,32'h200,  1'b1,2'd2,1'b0,1'b0);
        step("push300ov", 1'b1,1'b0,1'b1,1'b0,32'h300, 1'b0,1'b0,32'h300,  1'b1,2'd2,1'b1,1'b0);
        step("idle_ov",   1'b1,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h300,  1'b1,2'd2,1'b0,1'b0);
        step("pop_ov1",   1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1'b0,32'h200,  1'b1,2'd1,1'b0,1'b0);
        step("pop_ov2",   1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("pop_empty", 1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b1);
        step("idle_unf",  1'b1,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("pushpop44", 1'b1,1'b0,1'b1,1'b1,32'h44,  1'b0,1'b0,32'h44,   1'b1,2'd1,1'b0,1'b0);
        step("flush",     1'b1,1'b1,1'b0,1'b0,32'h0,   1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("ck_push100",1'b1,1'b0,1'b1,1'b0,32'h100, 1'b0,1'b0,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("ck_push200",1'b1,1'b0,1'b1,1'b0,32'h200, 1'b1,1'b0,32'h200,  1'b1,2'd2,1'b0,1'b0);
        step("ck_pop",    1'b1,1'b0,1'b0,1'b1,32'h0,   1'b0,1'b0,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("ck_push500",1'b1,1'b0,1'b1,1'b0,32'h500, 1'b0,1'b0,32'h500,  1'b1,2'd2,1'b0,1'b0);
        // ckpt alongside restore must be ignored; the next restore proves it
        step("restore1",  1'b1,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("flush_rs",  1'b1,1'b1,1'b1,1'b0,32'h600, 1'b1,1'b1,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("restore2",  1'b1,1'b0,1'b1,1'b1,32'h900, 1'b0,1'b1,32'h100,  1'b1,2'd1,1'b0,1'b0);
        step("push700",   1'b1,1'b0,1'b1,1'b0,32'h700, 1'b0,1'b0,32'h700,  1'b1,2'd2,1'b0,1'b0);
        step("rst_push",  1'b0,1'b0,1'b1,1'b0,32'h800, 1'b0,1'b0,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("rst_restore",1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,1'b1,32'h0,    1'b0,2'd0,1'b0,1'b0);
        step("post_push", 1'b1,1'b0,1'b1,1'b0,32'hABC, 1'b0,1'b0,32'hABC,  1'b1,2'd1,1'b0,1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
